// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Optional statistics counters (BrCount, MispredCount) are enabled by defining BTB_STATS_EN.
module branch_target_predictor #(
  parameter int ENTRIES = 64,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        StallE,
  input  logic        BrValidE,
  input  logic [31:0] PCE,
  input  logic        BranchE,
  input  logic [31:0] BranchTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredE,
  output logic [31:0] RedirectPCE
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] BrCount,
  output logic [31:0] MispredCount
`endif
);

  localparam int TAG_W = 32 - IDX_W - 2;

  logic [ENTRIES-1:0] valid;
  logic [1:0]         ctr        [ENTRIES];
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [31:0]        target_mem [ENTRIES];

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             hit_f, hit_e;
  logic             upd_e;
  logic             mispred_raw;
  logic             unused_pc_lsbs;

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[31:IDX_W+2];
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[31:IDX_W+2];
  assign unused_pc_lsbs = ^{PCF[1:0], PCE[1:0]};

  // Lookup reads current array contents only; a same-cycle write is seen next cycle.
  assign hit_f       = valid[idx_f] && (tag_mem[idx_f] == tag_f);
  assign PredTakenF  = rst_n && hit_f && ctr[idx_f][1];
  assign PredTargetF = hit_f ? target_mem[idx_f] : 32'h0;

  assign hit_e = valid[idx_e] && (tag_mem[idx_e] == tag_e);
  assign upd_e = BrValidE && !StallE;

  assign mispred_raw = (PredTakenE != BranchE) ||
                       (BranchE && PredTakenE && (PredTargetE != BranchTargetE));
  assign MispredE    = rst_n && upd_e && mispred_raw;
  assign RedirectPCE = BranchE ? BranchTargetE : PCE + 32'd4;

  // Control state: valid bits and direction counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
    end else if (upd_e) begin
      if (hit_e) begin
        if (BranchE) begin
          if (ctr[idx_e] != 2'b11) ctr[idx_e] <= ctr[idx_e] + 2'd1;
        end else begin
          if (ctr[idx_e] != 2'b00) ctr[idx_e] <= ctr[idx_e] - 2'd1;
        end
      end else if (BranchE) begin
        valid[idx_e] <= 1'b1;
        ctr[idx_e]   <= 2'b10;
      end
    end
  end

  // NOTE: tag/target storage has no reset; valid gates every use, so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (rst_n && upd_e && BranchE) begin
      tag_mem[idx_e]    <= tag_e;
      target_mem[idx_e] <= BranchTargetE;
    end
  end

`ifdef BTB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      BrCount      <= '0;
      MispredCount <= '0;
    end else begin
      if (upd_e)    BrCount      <= BrCount + 32'd1;
      if (MispredE) MispredCount <= MispredCount + 32'd1;
    end
  end
`endif

endmodule
